demux1x4_tdm: RTL and testbench
===============================

# demux1x4_tdm

Receive-side counterpart of the 4:1 mux. It takes a time-division-multiplexed serial stream, where one lane is sent per enabled cycle, together with a frame-sync strobe that marks slot 0. It rebuilds each 4-bit frame and presents it as a registered parallel word with a one-cycle valid pulse. It sits after any `mux4x1` whose `sel` is driven by a free-running slot counter, and closes the serial loop back to parallel data.

## Interface
- `LANES`, default 4: lanes per frame; must be a power of two, ≥2.
- `SEL_W`, default `$clog2(LANES)` = 2: width of the slot index.

Ports (name, direction, width, meaning):
- `clk`: input, 1. Single clock; all state updates on the rising edge.
- `rst`: input, 1. Synchronous, active-high reset.
- `en`: input, 1. Slot strobe. One serial bit is consumed per cycle with `en`=1.
- `in`: input, 1. Serial data bit for the current slot.
- `sync`: input, 1. Frame sync, qualified by `en`. Marks that `in` is slot 0.
- `out`: output, LANES. Last completed frame; slot k maps to `out[k]`.
- `valid`: output, 1. One-cycle pulse when `out` is updated.
- `sel`: output, SEL_W. Slot index the next enabled bit will be written to.
- `err`: output, 1. One-cycle pulse when `sync` arrives with `sel`≠0 in LOCK.

## Operation
- Reset values: `out`=0, `valid`=0, `sel`=0, `err`=0, `state`=HUNT, partial-frame register=0.
- All actions require `en`=1. With `en`=0, all state and registers hold; `valid` and `err` are 0.
- States are HUNT and LOCK.
- HUNT:
  - `en`=1 and `sync`=0: bit discarded, `sel` stays 0.
  - `en`=1 and `sync`=1: `in` goes to partial[0], `sel`←1, go to LOCK.
- LOCK, `en`=1 and `sync`=0:
  - `in` goes to partial[`sel`].
  - `sel`←`sel`+1, modulo LANES.
- LOCK, `en`=1 and `sync`=1 and `sel`=0: normal frame boundary, handled exactly as the `sync`=0 case.
- LOCK, `en`=1 and `sync`=1 and `sel`≠0 (misaligned sync):
  - `err` pulses.
  - The partial frame is discarded (cleared to 0).
  - `in` goes to partial[0] and `sel`←1.
  - No `valid` for the discarded frame.
- Frame complete: the enabled write to slot LANES-1 (no misaligned sync) does all of the following:
  - `out`←{`in`, partial[LANES-2:0]}.
  - `valid`=1 on the next cycle.
  - `sel` wraps to 0.
- LOCK is free-running. A missing `sync` at slot 0 is not an error. Only `rst` returns the block to HUNT.
- A misaligned `sync` on the slot-(LANES-1) cycle is treated as a resync, not a completion. `valid` stays 0 and `err` goes to 1.
- `valid` and `err` are never both 1 in the same cycle.

## Timing
- The bit for slot LANES-1 sampled on edge N gives `out`/`valid` visible after edge N; `valid` is high for exactly that one cycle.
- Latency is 1 cycle from the last slot bit to the word.
- The first `valid` comes LANES enabled cycles after the accepted `sync`.
- With `en` held at 1, `valid` repeats every LANES cycles.
- `out` holds its value between pulses.
- `sel` is registered and updates on the same edge that consumes the bit.
- `rst` asserted mid-frame: the partial frame is lost, no `valid` is produced, and all outputs take reset values on the next edge. `rst` has priority over `en`/`sync` in the same cycle.

## Structure
- Shared package `tdm_pkg`: `LANES_DEF`=4, `SEL_W_DEF`=2, state enum `tdm_state_t` {HUNT, LOCK}. This package is also imported by the future TX-side slot counter.
- One sub-module, `tdm_slot_ctr`: an SEL_W-bit counter with `en`, synchronous load-to-1 on sync, wrap, and a `last` flag (`sel`==LANES-1).
- The top level holds the FSM, the partial register, `out`, `valid` and `err`.

## Test plan
- Reset, then `en`=1, `sync`=1 with `in` bits 1,0,1,1 over 4 cycles → `out`=4'b1101 with `valid` for 1 cycle on the 5th edge; `sel` sequence 1,2,3,0.
- Continuous stream, with `sync` every 4th cycle, of frames 4'hA then 4'h5 → `valid` pulses exactly 4 cycles apart with `out`=A then 5; `err` never asserted.
- In HUNT, `en`=1 for 6 cycles with `sync`=0 → `sel` stays 0, no `valid`. The same frame with `en` toggling 1,0,1,0,… → identical `out` and `valid` delayed to the 8th edge.
- LOCK at `sel`=2, `sync`=1, `in`=1 → `err` pulse, `sel`=1. The next 3 bits 0,0,0 → `out`=4'b0001, and no `valid` for the aborted frame.
- Assert `rst` at `sel`=3 together with `en`=1 → no `valid`; `out`=0, `sel`=0, state HUNT; the next `sync` frame is received correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the RX demux and the TX-side slot counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdm_pkg;
    localparam int LANES_DEF = 4;
    localparam int SEL_W_DEF = 2;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: load-to-1 on sync, increment with natural wrap, last-slot flag.
// Latency: sel updates on the edge that consumes the slot.
// Backpressure: none; holds when neither inc nor load is asserted.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    // LANES is a power of two, so the SEL_W-bit overflow is the modulo-LANES wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= '0;
        end else if (load) begin
            sel <= SEL_W'(1);
        end else if (inc) begin
            sel <= sel + SEL_W'(1);
        end
    end

    assign last = (sel == SEL_W'(LANES - 1));

endmodule

// File: rtl/demux1x4_tdm.sv
// 1:LANES TDM demux: rebuilds frames from a serial stream aligned by a slot-0 sync strobe.
// Latency: 1 cycle from the last slot bit to out/valid.
// Backpressure: none; en=0 stalls all state, valid/err are single-cycle pulses.
module demux1x4_tdm
    import tdm_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             sync,
    output logic [LANES-1:0] out,
    output logic             valid,
    output logic [SEL_W-1:0] sel,
    output logic             err
);

    tdm_state_t       state, state_nxt;
    logic [LANES-1:0] partial, partial_nxt;
    logic [LANES-1:0] out_nxt;
    logic             valid_nxt, err_nxt;
    logic             ctr_inc, ctr_load, last;
    logic             misalign, complete;

    tdm_slot_ctr #(.LANES(LANES), .SEL_W(SEL_W)) u_slot_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (ctr_inc),
        .load (ctr_load),
        .sel  (sel),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == HUNT && en && sync) begin
            state_nxt = LOCK;
        end
    end

    // Any enabled sync forces sel to 1: a first lock, an aligned slot-0 sync
    // (same as a normal increment) or a resync after a misaligned one.
    always_comb begin
        ctr_inc     = en && (state == LOCK);
        ctr_load    = en && sync;
        misalign    = en && sync && (state == LOCK) && (sel != '0);
        complete    = en && (state == LOCK) && last && !misalign;
        partial_nxt = partial;
        out_nxt     = out;
        if (misalign) begin
            partial_nxt    = '0;
            partial_nxt[0] = in;
        end else if (en && (state == LOCK || sync)) begin
            partial_nxt[sel] = in;
        end
        if (complete) begin
            out_nxt = {in, partial[LANES-2:0]};
        end
        valid_nxt = complete;
        err_nxt   = misalign;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            partial <= '0;
            out     <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            partial <= partial_nxt;
            out     <= out_nxt;
            valid   <= valid_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_demux1x4_tdm.sv
// Bench for demux1x4_tdm: directed scenarios plus random traffic against a frame-level model.
module tb_demux1x4_tdm;
    localparam int LANES = 4;

    logic       clk = 1'b0;
    logic       rst, en, in_b, sync;
    logic [3:0] out_w;
    logic       valid, err;
    logic [1:0] sel;

    int vectors     = 0;
    int miscompares = 0;

    // Frame-level reference state
    bit       m_locked;
    int       m_slot;
    bit [3:0] m_part;
    bit [3:0] m_out;
    bit       m_valid, m_err;

    demux1x4_tdm #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (in_b),
        .sync  (sync),
        .out   (out_w),
        .valid (valid),
        .sel   (sel),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s, input bit i);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_slot   = 0;
            m_part   = '0;
            m_out    = '0;
        end else if (e) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked  = 1'b1;
                    m_part[0] = i;
                    m_slot    = 1;
                end
            end else if (s && m_slot != 0) begin
                m_err     = 1'b1;
                m_part    = '0;
                m_part[0] = i;
                m_slot    = 1;
            end else begin
                m_part[m_slot] = i;
                if (m_slot == LANES - 1) begin
                    m_out   = m_part;
                    m_valid = 1'b1;
                    m_slot  = 0;
                end else begin
                    m_slot = m_slot + 1;
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit s, input bit i);
        rst  = r;
        en   = e;
        sync = s;
        in_b = i;
        @(posedge clk);
        model_step(r, e, s, i);
        #1;
        check("out", out_w, m_out);
        check("valid", valid, m_valid);
        check("sel", sel, m_slot);
        check("err", err, m_err);
        if (valid && err) check("valid_err_exclusive", 1, 0);
    endtask

    task automatic send_frame(input bit [3:0] f, input bit with_sync);
        for (int k = 0; k < LANES; k++) tick(1'b0, 1'b1, with_sync && k == 0, f[k]);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; in_b = 1'b0;
        m_locked = 0; m_slot = 0; m_part = 0; m_out = 0; m_valid = 0; m_err = 0;

        tick(1, 0, 0, 0);
        tick(1, 1, 1, 1);
        check("reset_out", out_w, 4'h0);
        check("reset_sel", sel, 2'd0);

        // Bits 1,0,1,1 into slots 0..3; sel walks 1,2,3,0
        tick(0, 1, 1, 1); check("seq_sel1", sel, 2'd1);
        tick(0, 1, 0, 0); check("seq_sel2", sel, 2'd2);
        tick(0, 1, 0, 1); check("seq_sel3", sel, 2'd3);
        tick(0, 1, 0, 1); check("seq_sel0", sel, 2'd0);
        check("frame1_out", out_w, 4'b1101);
        check("frame1_valid", valid, 1'b1);
        tick(0, 0, 0, 0);
        check("frame1_pulse_end", valid, 1'b0);

        send_frame(4'hA, 1);
        check("frameA", out_w, 4'hA);
        send_frame(4'h5, 1);
        check("frame5", out_w, 4'h5);

        // HUNT discards unsynced bits; then an en-toggled frame
        tick(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) tick(0, 1, 0, $urandom_range(0, 1));
        check("hunt_sel", sel, 2'd0);
        for (int k = 0; k < LANES; k++) begin
            tick(0, 1, k == 0, k != 1);
            tick(0, 0, 0, 1'b0);
        end
        check("toggle_out", out_w, 4'b1101);

        // Misaligned sync at sel=2 resyncs
        tick(0, 1, 1, 1);
        tick(0, 1, 0, 1);
        tick(0, 1, 1, 1);
        check("misalign_err", err, 1'b1);
        check("misalign_sel", sel, 2'd1);
        for (int k = 0; k < 3; k++) tick(0, 1, 0, 0);
        check("resync_out", out_w, 4'b0001);

        // Reset mid-frame at sel=3
        for (int k = 0; k < 3; k++) tick(0, 1, k == 0, 1);
        tick(1, 1, 0, 1);
        check("midrst_out", out_w, 4'h0);
        check("midrst_valid", valid, 1'b0);
        send_frame(4'h9, 1);
        check("after_rst_out", out_w, 4'h9);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
